// File: rtl/buffer_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// buffer_wr_arbiter_if
// Bundles the producer request side and the buffer write port of the
// buffer write arbiter.
//   req        producer write requests, one bit per producer (level)
//   req_data   producer data, producer i in bits [i*DATA_L +: DATA_L]
//   grant      one-hot current owner, all-zero when idle
//   done       one-cycle pulse to the owner when its transfer ends
//   err        one-cycle pulse alongside done when a transfer aborts
//   buf_we     buffer write strobe
//   buf_din    buffer write data
//   buf_w_ack  buffer write acknowledge (level)
//   buf_full   buffer full flag
// Modports:
//   master  the arbiter itself
//   slave   the producers and the buffer around it
// ----------------------------------------------------------------------------
interface buffer_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_L = 16
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_L-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    err;
  logic                    buf_we;
  logic [DATA_L-1:0]       buf_din;
  logic                    buf_w_ack;
  logic                    buf_full;

  modport master (
    input  req, req_data, buf_w_ack, buf_full,
    output grant, done, err, buf_we, buf_din
  );

  modport slave (
    output req, req_data, buf_w_ack, buf_full,
    input  grant, done, err, buf_we, buf_din
  );
endinterface

// File: rtl/buffer_wr_arbiter.sv
// ----------------------------------------------------------------------------
// buffer_wr_arbiter
// Shares the write port of one buffer FIFO among N_REQ producers using
// round-robin arbitration, and sequences the buffer's level-sensitive
// we / w_ack handshake: raise we, wait for ack high, drop we, wait for ack
// low, then pulse done to the owner.
// Ports:
//   clk_i   system clock, everything on the rising edge
//   rst_i   synchronous reset, active high
//   bus_if  buffer_wr_arbiter_if.master (requests, grant/done/err, buffer port)
// Parameters:
//   N_REQ        number of producers (2..8)
//   DATA_L       data width, must match the buffer
//   TIMEOUT_CYC  cycles allowed per ack edge before the transfer is aborted
// Build option:
//   ARB_TIMEOUT_EN  when defined, a 4-bit watchdog aborts a stalled handshake
//                   and flags err; when undefined the FSM waits on the ack
//                   indefinitely and err is tied low.
// ----------------------------------------------------------------------------
module buffer_wr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_L      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  buffer_wr_arbiter_if.master bus_if
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_LSB = N_REQ'(1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  // Elaboration-time guard on the supported parameter range
  if ((N_REQ < 2) || (N_REQ > 8) || (TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 15)) begin : g_param_chk
    $error("buffer_wr_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  done_q;
  logic              buf_we_q;
  logic [DATA_L-1:0] buf_din_q;

  logic              pick_vld_s;
  logic [IDX_W-1:0]  pick_idx_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYC - 1);
  logic [3:0] tmo_q;
  logic       err_pend_q;
  logic       err_q;
`endif

  // Round-robin pick: scan from the far end toward rr_ptr+1 so the nearest
  // active requester after the last owner overwrites any earlier hit.
  always_comb begin
    int  idx;
    logic hit;
    pick_vld_s = 1'b0;
    pick_idx_s = '0;
    idx        = 0;
    hit        = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx        = (int'(rr_ptr_q) + off) % N_REQ;
      hit        = bus_if.req[idx];
      pick_idx_s = hit ? IDX_W'(idx) : pick_idx_s;
      pick_vld_s = pick_vld_s | hit;
    end
  end

  // Handshake FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= PTR_RST;
      owner_q    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      buf_we_q   <= 1'b0;
      buf_din_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q      <= 4'd0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      // done and err are single-cycle pulses
      done_q <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          // buf_full only gates new grants; pending requests simply wait
          if (pick_vld_s && !bus_if.buf_full) begin
            grant_q   <= ONE_LSB << pick_idx_s;
            owner_q   <= pick_idx_s;
            buf_din_q <= bus_if.req_data[int'(pick_idx_s) * DATA_L +: DATA_L];
            buf_we_q  <= 1'b1;
            state_q   <= S_ASSERT;
`ifdef ARB_TIMEOUT_EN
            tmo_q      <= 4'd0;
            err_pend_q <= 1'b0;
`endif
          end
        end
        S_ASSERT: begin
          if (bus_if.buf_w_ack) begin
            buf_we_q <= 1'b0;
            state_q  <= S_RELEASE;
`ifdef ARB_TIMEOUT_EN
            tmo_q    <= 4'd0;
          end else if (tmo_q == TMO_LAST) begin
            // ack never rose: drop the strobe and close out with err
            buf_we_q   <= 1'b0;
            err_pend_q <= 1'b1;
            tmo_q      <= 4'd0;
            state_q    <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + 4'd1;
`endif
          end
        end
        S_RELEASE: begin
          if (!bus_if.buf_w_ack) begin
            state_q <= S_FINISH;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= 4'd0;
          end else if (tmo_q == TMO_LAST) begin
            // ack stuck high: give up waiting for it to fall
            err_pend_q <= 1'b1;
            tmo_q      <= 4'd0;
            state_q    <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + 4'd1;
`endif
          end
        end
        S_FINISH: begin
          // The owner becomes lowest priority for the next round, even after an abort
          done_q   <= grant_q;
          grant_q  <= '0;
          rr_ptr_q <= owner_q;
          state_q  <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
          err_q      <= err_pend_q;
          err_pend_q <= 1'b0;
`endif
        end
        default: begin
          state_q  <= S_IDLE;
          grant_q  <= '0;
          buf_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.grant   = grant_q;
  assign bus_if.done    = done_q;
  assign bus_if.buf_we  = buf_we_q;
  assign bus_if.buf_din = buf_din_q;
`ifdef ARB_TIMEOUT_EN
  assign bus_if.err     = err_q;
`else
  assign bus_if.err     = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_buffer_wr_arbiter
// Directed bench for buffer_wr_arbiter (N_REQ=4, DATA_L=16, TIMEOUT_CYC=15).
// The buffer is modelled as raising w_ack one cycle after it sees we and
// dropping it as soon as we falls; ack_en_r can hold the ack low.
// Inputs change and outputs are sampled on the falling clock edge.
// The timeout scenario is included only when ARB_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_buffer_wr_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_L = 16;

  logic clk_r    = 1'b0;
  logic rst_r    = 1'b1;
  logic we_d_r   = 1'b0;
  logic ack_en_r = 1'b1;
  int   total_r  = 0;
  int   bad_r    = 0;

  buffer_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_L(DATA_L)) bus_if ();

  buffer_wr_arbiter #(.N_REQ(N_REQ), .DATA_L(DATA_L), .TIMEOUT_CYC(15)) u_dut (
    .clk_i  (clk_r),
    .rst_i  (rst_r),
    .bus_if (bus_if.master)
  );

  // 100 MHz clock
  always #5 clk_r = ~clk_r;

  // Buffer ack model: ack rises one cycle after we, falls together with we
  always @(posedge clk_r) we_d_r <= bus_if.buf_we;
  assign bus_if.buf_w_ack = ack_en_r & bus_if.buf_we & we_d_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_r++;
    if (got !== want) begin
      bad_r++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_r);
  endtask

  task automatic do_reset();
    rst_r              = 1'b1;
    bus_if.req         = '0;
    bus_if.req_data    = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    bus_if.buf_full    = 1'b0;
    ack_en_r           = 1'b1;
    tick(2);
    rst_r = 1'b0;
  endtask

  // Polls for a grant within a cycle budget; a timeout shows up as a mismatch
  task automatic wait_grant(input string tag, input logic [3:0] want);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_r);
      if (bus_if.grant != 4'd0) break;
    end
    check(tag, 32'(bus_if.grant), 32'(want));
  endtask

  task automatic wait_done(input string tag, input logic [3:0] want);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_r);
      if (bus_if.done != 4'd0) break;
    end
    check(tag, 32'(bus_if.done), 32'(want));
    check({tag, "_gnt_clr"}, 32'(bus_if.grant), 32'd0);
  endtask

  initial begin
    logic [4:0] we_seen;
    logic [4:0] done0_seen;
    int         we_cnt;

    // ---- reset state
    do_reset();
    check("rst_grant", 32'(bus_if.grant), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_err", 32'(bus_if.err), 32'd0);
    check("rst_we", 32'(bus_if.buf_we), 32'd0);
    check("rst_din", 32'(bus_if.buf_din), 32'd0);

    // ---- 1: single request, exact timing
    bus_if.req_data[15:0] = 16'h1234;
    bus_if.req = 4'b0001;
    we_seen    = '0;
    done0_seen = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_r);
      we_seen[k]    = bus_if.buf_we;
      done0_seen[k] = bus_if.done[0];
      if (k == 0) begin
        check("t1_grant", 32'(bus_if.grant), 32'h1);
        check("t1_din", 32'(bus_if.buf_din), 32'h1234);
      end
    end
    bus_if.req = 4'b0000;
    check("t1_we_shape", 32'(we_seen), 32'b00011);
    check("t1_done_at4", 32'(done0_seen), 32'b10000);
    check("t1_err", 32'(bus_if.err), 32'd0);
    tick(1);
    check("t1_no_regrant", 32'(bus_if.grant), 32'd0);

    // ---- 2: all four requesting, eight transfers in round-robin order
    do_reset();
    bus_if.req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_grant($sformatf("t2_grant%0d", t), 4'(1 << (t % 4)));
      wait_done($sformatf("t2_done%0d", t), 4'(1 << (t % 4)));
    end
    bus_if.req = 4'b0000;
    tick(2);
    check("t2_idle", 32'(bus_if.grant), 32'd0);

    // ---- 3: buf_full holds off the grant
    do_reset();
    bus_if.buf_full = 1'b1;
    bus_if.req      = 4'b0100;
    tick(4);
    check("t3_full_grant", 32'(bus_if.grant), 32'd0);
    check("t3_full_we", 32'(bus_if.buf_we), 32'd0);
    bus_if.buf_full = 1'b0;
    tick(1);
    check("t3_grant", 32'(bus_if.grant), 32'h4);
    check("t3_din", 32'(bus_if.buf_din), 32'hC222);
    wait_done("t3_done", 4'b0100);
    bus_if.req = 4'b0000;

    // ---- 4: reset while in ASSERT
    do_reset();
    bus_if.req = 4'b0010;
    wait_grant("t4_grant", 4'b0010);
    rst_r = 1'b1;
    tick(1);
    rst_r      = 1'b0;
    bus_if.req = 4'b1001;
    check("t4_rst_we", 32'(bus_if.buf_we), 32'd0);
    check("t4_rst_grant", 32'(bus_if.grant), 32'd0);
    check("t4_rst_done", 32'(bus_if.done), 32'd0);
    tick(1);
    check("t4_tie_grant", 32'(bus_if.grant), 32'h1);
    check("t4_tie_din", 32'(bus_if.buf_din), 32'hA000);
    wait_done("t4_done", 4'b0001);
    bus_if.req = 4'b0000;

    // ---- 5: request and data change after the grant
    do_reset();
    bus_if.req_data[31:16] = 16'hABCD;
    bus_if.req             = 4'b0010;
    wait_grant("t5_grant", 4'b0010);
    check("t5_din", 32'(bus_if.buf_din), 32'hABCD);
    bus_if.req             = 4'b0000;
    bus_if.req_data[31:16] = 16'h5555;
    tick(1);
    check("t5_din_held", 32'(bus_if.buf_din), 32'hABCD);
    check("t5_we_held", 32'(bus_if.buf_we), 32'd1);
    wait_done("t5_done", 4'b0010);

`ifdef ARB_TIMEOUT_EN
    // ---- 6: ack stuck low, abort after 15 cycles, next requester served
    do_reset();
    ack_en_r   = 1'b0;
    bus_if.req = 4'b0011;
    wait_grant("t6_grant", 4'b0001);
    we_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_r);
      if (!bus_if.buf_we) break;
      we_cnt++;
    end
    check("t6_we_cycles", 32'(we_cnt), 32'd15);
    tick(1);
    check("t6_done", 32'(bus_if.done), 32'h1);
    check("t6_err", 32'(bus_if.err), 32'd1);
    ack_en_r   = 1'b1;
    bus_if.req = 4'b0010;
    tick(1);
    check("t6_next_grant", 32'(bus_if.grant), 32'h2);
    check("t6_err_pulse", 32'(bus_if.err), 32'd0);
    wait_done("t6_done2", 4'b0010);
    bus_if.req = 4'b0000;
`else
    we_cnt = 0;
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total_r, bad_r);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
